sevenseg_scan_driver: RTL

- Downstream consumer of the free-running 2-bit mod-4 digit counter.
- Drives a 4-digit multiplexed seven-segment display from a 16-bit hex value (4 nibbles).
- Takes new values via a valid/ready handshake, applies them only on frame boundaries (no mid-frame tearing).
- Inserts dead-time blanking on every digit change and can blank leading zeros.

---
 rtl/sevenseg_scan_driver.sv | 78 +++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: 4-digit multiplexed hex display with frame-aligned updates and digit dead-time
module sevenseg_scan_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done
);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;
  localparam logic [3:0] BC = 4'(BLANK_CYCLES);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] disp, pend, disp_n;
  logic [3:0]  dpr, pend_dp, dpr_n, cnt, cnt_n, supp, an_hi;
  logic [1:0]  prev_sel;
  logic [0:0]  state, state_n;
  logic [6:0]  seg_hi;
  logic        accept, change, boundary, load, on, dp_hi;
  assign accept   = data_valid & data_ready;
  assign change   = digit_sel != prev_sel;
  assign boundary = prev_sel == 2'd3 && digit_sel == 2'd0;
  assign load     = boundary & ~data_ready;
  // Outputs are registered from next-state values so the dark window is exactly BLANK_CYCLES+1
  always_comb begin
    disp_n  = load ? pend : disp;
    dpr_n   = load ? pend_dp : dpr;
    state_n = change ? BLANK : (state == BLANK && cnt == 4'd0) ? DRIVE : state;
    cnt_n   = change ? BC : (state == BLANK && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    supp    = 4'b0000;
    supp[3] = LZ_BLANK && disp_n[15:12] == 4'd0 && !dpr_n[3];
    supp[2] = supp[3] && disp_n[11:8] == 4'd0 && !dpr_n[2];
    supp[1] = supp[2] && disp_n[7:4] == 4'd0 && !dpr_n[1];
    on      = state_n == DRIVE && !supp[digit_sel];
    an_hi   = on ? 4'b0001 << digit_sel : 4'b0000;
    seg_hi  = on ? HEX[disp_n[{digit_sel, 2'b00} +: 4]] : 7'h00;
    dp_hi   = on & dpr_n[digit_sel];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp       <= '0;
      dpr        <= '0;
      pend       <= '0;
      pend_dp    <= '0;
      data_ready <= 1'b1;
      prev_sel   <= '0;
      cnt        <= BC;
      state      <= BLANK;
      frame_done <= 1'b0;
      anode      <= {4{ACTIVE_LOW}};
      segments   <= {7{ACTIVE_LOW}};
      dp         <= ACTIVE_LOW;
    end else begin
      disp       <= disp_n;
      dpr        <= dpr_n;
      pend       <= accept ? data_in : pend;
      pend_dp    <= accept ? dp_in : pend_dp;
      data_ready <= accept ? 1'b0 : load ? 1'b1 : data_ready;
      prev_sel   <= digit_sel;
      cnt        <= cnt_n;
      state      <= state_n;
      frame_done <= boundary;
      anode      <= an_hi ^ {4{ACTIVE_LOW}};
      segments   <= seg_hi ^ {7{ACTIVE_LOW}};
      dp         <= dp_hi ^ ACTIVE_LOW;
    end
  end
endmodule
